// File: rtl/rpn_sequencer.sv
// Program sequencer for an RPN stack calculator: runs a small program memory
// one instruction per step and issues push/op commands while tracking stack depth.
module rpn_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int MAX_DEPTH  = 1023
) (
  input  logic        step,
  input  logic        nrst,
  input  logic        prog_we,
  input  logic [4:0]  prog_addr,
  input  logic [18:0] prog_data,
  input  logic        start,
  input  logic [9:0]  cnt,
  input  logic [15:0] calc_out,
  output logic        push,
  output logic [15:0] d,
  output logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [4:0]  pc,
  output logic [15:0] result
);

  localparam int PCW = 5;
  localparam int DW  = 10;
  localparam logic [PCW-1:0] PC_LAST   = PCW'(PROG_DEPTH - 1);
  localparam logic [DW-1:0]  DEPTH_MAX = DW'(MAX_DEPTH);

  localparam logic [2:0] OPC_NOP  = 3'b000;
  localparam logic [2:0] OPC_PUSH = 3'b001;
  localparam logic [2:0] OPC_NEG  = 3'b010;
  localparam logic [2:0] OPC_ADD  = 3'b011;
  localparam logic [2:0] OPC_MUL  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] ERR_END   = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_DONE  = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  state_t          state_r;
  logic [PCW-1:0]  pc_r;
  logic [DW-1:0]   depth_r;
  logic [15:0]     result_r;
  logic [1:0]      err_code_r;
  logic [18:0]     mem_r [0:PROG_DEPTH-1];

  logic [18:0]     instr_s;
  logic            push_s;
  logic [15:0]     d_s;
  logic [1:0]      op_s;
  logic            fault_s;
  logic [1:0]      fault_code_s;
  logic            halt_s;
  logic [DW-1:0]   depth_nxt_s;

  // Program memory write port; contents deliberately survive reset.
  always_ff @(posedge step) begin
    if (prog_we && (state_r != S_RUN)) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

  // Decode the current instruction; a faulting instruction issues no command.
  always_comb begin
    instr_s      = mem_r[pc_r];
    push_s       = 1'b0;
    d_s          = 16'd0;
    op_s         = 2'b00;
    fault_s      = 1'b0;
    fault_code_s = ERR_END;
    halt_s       = 1'b0;
    depth_nxt_s  = depth_r;
    if (state_r == S_RUN) begin
      case (instr_s[18:16])
        OPC_NOP: op_s = 2'b00;
        OPC_PUSH: begin
          if (depth_r == DEPTH_MAX) begin
            fault_s      = 1'b1;
            fault_code_s = ERR_OVER;
          end else begin
            push_s      = 1'b1;
            d_s         = instr_s[15:0];
            depth_nxt_s = depth_r + 10'd1;
          end
        end
        OPC_NEG: begin
          if (depth_r < 10'd1) begin
            fault_s      = 1'b1;
            fault_code_s = ERR_UNDER;
          end else begin
            op_s = 2'b01;
          end
        end
        OPC_ADD, OPC_MUL: begin
          if (depth_r < 10'd2) begin
            fault_s      = 1'b1;
            fault_code_s = ERR_UNDER;
          end else begin
            op_s        = (instr_s[18:16] == OPC_ADD) ? 2'b10 : 2'b11;
            depth_nxt_s = depth_r - 10'd1;
          end
        end
        OPC_HALT: halt_s = 1'b1;
        default: begin
          fault_s      = 1'b1;
          fault_code_s = ERR_ILL;
        end
      endcase
    end else begin
      halt_s = 1'b0;
    end
  end

  // Sequencer state machine: pc, depth tracking, status and result capture.
  always_ff @(posedge step or negedge nrst) begin
    if (!nrst) begin
      state_r    <= S_IDLE;
      pc_r       <= 5'd0;
      depth_r    <= 10'd0;
      result_r   <= 16'd0;
      err_code_r <= 2'b00;
    end else begin
      case (state_r)
        S_RUN: begin
          if (fault_s) begin
            state_r    <= S_ERROR;
            err_code_r <= fault_code_s;
          end else if (halt_s) begin
            state_r  <= S_DONE;
            result_r <= calc_out;
          end else begin
            depth_r <= depth_nxt_s;
            // The last slot issues its command, then stops rather than wrapping.
            if (pc_r == PC_LAST) begin
              state_r    <= S_ERROR;
              err_code_r <= ERR_END;
            end else begin
              pc_r <= pc_r + 5'd1;
            end
          end
        end
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_r    <= S_RUN;
            pc_r       <= 5'd0;
            depth_r    <= cnt;
            err_code_r <= 2'b00;
          end else if (prog_we) begin
            state_r <= S_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign push     = push_s;
  assign d        = d_s;
  assign op       = op_s;
  assign busy     = (state_r == S_RUN);
  assign done     = (state_r == S_DONE);
  assign err      = (state_r == S_ERROR);
  assign err_code = err_code_r;
  assign pc       = pc_r;
  assign result   = result_r;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer: a behavioural calculator closes the loop,
// and expected commands are queued per program and popped each RUN cycle.
module tb_rpn_sequencer;

  logic        step = 1'b0;
  logic        nrst = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = 5'd0;
  logic [18:0] prog_data = 19'd0;
  logic        start = 1'b0;
  logic [9:0]  cnt;
  logic [15:0] calc_out;
  logic        push;
  logic [15:0] d;
  logic [1:0]  op;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [4:0]  pc;
  logic [15:0] result;

  typedef struct packed {
    logic        p;
    logic [15:0] dd;
    logic [1:0]  o;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Calculator model
  logic [15:0] stk [0:1023];
  int          sp = 0;
  logic        calc_clr = 1'b0;
  logic        cnt_force = 1'b0;

  rpn_sequencer dut (
    .step(step), .nrst(nrst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .cnt(cnt), .calc_out(calc_out),
    .push(push), .d(d), .op(op), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .pc(pc), .result(result)
  );

  always #5 step = ~step;

  assign cnt      = cnt_force ? 10'd1023 : 10'(sp);
  assign calc_out = (sp > 0) ? stk[sp-1] : 16'd0;

  always @(posedge step) begin
    if (calc_clr) begin
      sp <= 0;
    end else if (push) begin
      stk[sp] <= d;
      sp      <= sp + 1;
    end else if (op == 2'b01 && sp >= 1) begin
      stk[sp-1] <= -stk[sp-1];
    end else if (op == 2'b10 && sp >= 2) begin
      stk[sp-2] <= stk[sp-2] + stk[sp-1];
      sp        <= sp - 1;
    end else if (op == 2'b11 && sp >= 2) begin
      stk[sp-2] <= stk[sp-2] * stk[sp-1];
      sp        <= sp - 1;
    end
  end

  function automatic logic [18:0] ins(input logic [2:0] opc, input logic [15:0] imm);
    return {opc, imm};
  endfunction

  task automatic exp_cmd(input logic p, input logic [15:0] dd, input logic [1:0] o);
    cmd_t c;
    c.p = p; c.dd = dd; c.o = o;
    exp_q.push_back(c);
  endtask

  task automatic load(input logic [4:0] a, input logic [18:0] v);
    @(negedge step);
    prog_we = 1'b1; prog_addr = a; prog_data = v;
    @(negedge step);
    prog_we = 1'b0;
  endtask

  task automatic calc_clear();
    @(negedge step); calc_clr = 1'b1;
    @(negedge step); calc_clr = 1'b0;
  endtask

  task automatic load_add_prog();
    load(5'd0, ins(3'b001, 16'd3));
    load(5'd1, ins(3'b001, 16'd4));
    load(5'd2, ins(3'b011, 16'd0));
    load(5'd3, ins(3'b111, 16'd0));
  endtask

  task automatic exp_add_prog();
    exp_cmd(1'b1, 16'd3, 2'b00);
    exp_cmd(1'b1, 16'd4, 2'b00);
    exp_cmd(1'b0, 16'd0, 2'b10);
    exp_cmd(1'b0, 16'd0, 2'b00);
  endtask

  // Pulse start, then compare each RUN cycle's command against the queue.
  task automatic run_prog(input int max_cyc, input int we_at, output int busy_cyc);
    cmd_t e;
    bit   ended = 1'b0;
    busy_cyc = 0;
    @(negedge step); start = 1'b1;
    @(negedge step); start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (c > 0) @(negedge step);
      prog_we = 1'b0;
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      if (c == we_at) begin
        prog_we = 1'b1; prog_addr = 5'd2; prog_data = ins(3'b111, 16'd0);
      end
      busy_cyc++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL extra_cmd cycle %0d: got push=%0b d=%0h op=%0b, required no RUN cycle", c, push, d, op);
      end else begin
        e = exp_q.pop_front();
        if ({push, d, op} !== e) begin
          n_err++;
          $display("FAIL cmd cycle %0d: got push=%0b d=%0h op=%0b, required push=%0b d=%0h op=%0b",
                   c, push, d, op, e.p, e.dd, e.o);
        end
      end
    end
    prog_we = 1'b0;
    n_vec++;
    if (!ended) begin
      n_err++;
      $display("FAIL timeout: still busy after %0d cycles, required to finish", max_cyc);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_cmds: %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_end(input string nm, input int bc, input int bc_exp, input logic [2:0] st,
                           input logic [1:0] ec, input logic [4:0] pc_exp);
    n_vec++;
    if (bc != bc_exp) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d, required %0d", nm, bc, bc_exp);
    end
    n_vec++;
    if ({busy, done, err} !== st || pc !== pc_exp || (err && err_code !== ec)) begin
      n_err++;
      $display("FAIL %s status: got bde=%03b ec=%0b pc=%0d, required bde=%03b ec=%0b pc=%0d",
               nm, {busy, done, err}, err_code, pc, st, ec, pc_exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge step);
    n_vec++;
    if ({push, d, op, busy, done, err, err_code, pc, result} !== 45'd0) begin
      n_err++;
      $display("FAIL reset_state: got push=%0b d=%0h op=%0b bde=%b ec=%0b pc=%0d res=%0h, required all 0",
               push, d, op, {busy, done, err}, err_code, pc, result);
    end
    nrst = 1'b1;
  endtask

  task automatic test_add();
    int bc;
    load_add_prog();
    calc_clear();
    exp_add_prog();
    run_prog(10, -1, bc);
    check_end("add", bc, 4, 3'b010, 2'b00, 5'd3);
    n_vec++;
    if (result !== 16'd7) begin
      n_err++;
      $display("FAIL add_result: got %0d, required 7", result);
    end
  endtask

  task automatic test_neg_mul();
    int bc;
    logic [15:0] r;
    load(5'd0, ins(3'b001, 16'd6));
    load(5'd1, ins(3'b010, 16'd0));
    load(5'd2, ins(3'b001, 16'd7));
    load(5'd3, ins(3'b100, 16'd0));
    load(5'd4, ins(3'b111, 16'd0));
    calc_clear();
    exp_cmd(1'b1, 16'd6, 2'b00);
    exp_cmd(1'b0, 16'd0, 2'b01);
    exp_cmd(1'b1, 16'd7, 2'b00);
    exp_cmd(1'b0, 16'd0, 2'b11);
    exp_cmd(1'b0, 16'd0, 2'b00);
    run_prog(10, -1, bc);
    check_end("neg_mul", bc, 5, 3'b010, 2'b00, 5'd4);
    r = 16'd0 - 16'd42;
    n_vec++;
    if (result !== r) begin
      n_err++;
      $display("FAIL neg_mul_result: got %0h, required %0h", result, r);
    end
  endtask

  task automatic test_underflow();
    int bc;
    load(5'd0, ins(3'b001, 16'd5));
    load(5'd1, ins(3'b011, 16'd0));
    load(5'd2, ins(3'b111, 16'd0));
    calc_clear();
    exp_cmd(1'b1, 16'd5, 2'b00);
    exp_cmd(1'b0, 16'd0, 2'b00);
    run_prog(10, -1, bc);
    check_end("underflow", bc, 2, 3'b001, 2'b01, 5'd1);
  endtask

  task automatic test_illegal();
    int bc;
    load(5'd0, ins(3'b101, 16'h1234));
    calc_clear();
    exp_cmd(1'b0, 16'd0, 2'b00);
    run_prog(10, -1, bc);
    check_end("illegal", bc, 1, 3'b001, 2'b11, 5'd0);
  endtask

  task automatic test_overflow();
    int bc;
    load(5'd0, ins(3'b001, 16'd1));
    calc_clear();
    cnt_force = 1'b1;
    exp_cmd(1'b0, 16'd0, 2'b00);
    run_prog(10, -1, bc);
    cnt_force = 1'b0;
    check_end("overflow", bc, 1, 3'b001, 2'b10, 5'd0);
  endtask

  task automatic test_nops();
    int bc;
    for (int a = 0; a < 32; a++) load(5'(a), ins(3'b000, 16'(a)));
    calc_clear();
    for (int a = 0; a < 32; a++) exp_cmd(1'b0, 16'd0, 2'b00);
    run_prog(40, -1, bc);
    check_end("nops", bc, 32, 3'b001, 2'b00, 5'd31);
  endtask

  task automatic test_reset_abort();
    int bc;
    load_add_prog();
    calc_clear();
    @(negedge step); start = 1'b1;
    @(negedge step); start = 1'b0;
    @(posedge step);
    #2 nrst = 1'b0;
    #1;
    n_vec++;
    if ({push, d, op, busy, done, err, err_code, pc, result} !== 45'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got push=%0b d=%0h op=%0b bde=%b pc=%0d res=%0h, required all 0",
               push, d, op, {busy, done, err}, pc, result);
    end
    @(negedge step); nrst = 1'b1;
    calc_clear();
    exp_add_prog();
    run_prog(10, -1, bc);
    check_end("rerun", bc, 4, 3'b010, 2'b00, 5'd3);
    n_vec++;
    if (result !== 16'd7) begin
      n_err++;
      $display("FAIL rerun_result: got %0d, required 7", result);
    end
  endtask

  task automatic test_we_during_run();
    int bc;
    calc_clear();
    exp_add_prog();
    run_prog(10, 0, bc);
    check_end("we_run", bc, 4, 3'b010, 2'b00, 5'd3);
    n_vec++;
    if (result !== 16'd7) begin
      n_err++;
      $display("FAIL we_run_result: got %0d, required 7", result);
    end
    load(5'd9, ins(3'b000, 16'd0));
    n_vec++;
    if ({busy, done, err} !== 3'b000) begin
      n_err++;
      $display("FAIL we_done_to_idle: got bde=%03b, required 000", {busy, done, err});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_neg_mul();
    test_underflow();
    test_illegal();
    test_overflow();
    test_nops();
    test_reset_abort();
    test_we_during_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
